pulse_width_generator: RTL and testbench

//  Programmable waveform source: emits FREQ_OUT with a high time and low time given in CLK cycles.

---
 rtl/pulse_width_generator_if.sv | 36 +++
 rtl/pulse_width_generator.sv | 150 +++++++++++++++
 tb/tb_pulse_width_generator.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_width_generator_if.sv
// Byte-write, run-control and waveform signals of pulse_width_generator.
// ONESHOT exists only when PULSE_WIDTH_GENERATOR_ONESHOT_EN is defined.
interface pulse_width_generator_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  WR_EN;
  logic [2:0]            WR_SEL;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  ENABLE;
`ifdef PULSE_WIDTH_GENERATOR_ONESHOT_EN
  logic                  ONESHOT;
`endif
  logic                  FREQ_OUT;
  logic                  PERIOD_DONE;
  logic                  COMMIT_PENDING;

`ifdef PULSE_WIDTH_GENERATOR_ONESHOT_EN
  modport master (
    output WR_EN, WR_SEL, WR_DATA, ENABLE, ONESHOT,
    input  FREQ_OUT, PERIOD_DONE, COMMIT_PENDING
  );
  modport slave (
    input  WR_EN, WR_SEL, WR_DATA, ENABLE, ONESHOT,
    output FREQ_OUT, PERIOD_DONE, COMMIT_PENDING
  );
`else
  modport master (
    output WR_EN, WR_SEL, WR_DATA, ENABLE,
    input  FREQ_OUT, PERIOD_DONE, COMMIT_PENDING
  );
  modport slave (
    input  WR_EN, WR_SEL, WR_DATA, ENABLE,
    output FREQ_OUT, PERIOD_DONE, COMMIT_PENDING
  );
`endif
endinterface

// File: rtl/pulse_width_generator.sv
// Programmable high/low-time waveform source with double-buffered timing.
// Optional one-shot mode: PULSE_WIDTH_GENERATOR_ONESHOT_EN.
module pulse_width_generator #(
  parameter int COUNTER_BITS = 16,
  parameter int DATA_WIDTH   = 8
) (
  input logic CLK,
  input logic RST_N,
  pulse_width_generator_if.slave bus
);
  localparam int CB = COUNTER_BITS;
  localparam int DW = DATA_WIDTH;
  localparam logic [CB-1:0] ONE = CB'(1);

`ifdef PULSE_WIDTH_GENERATOR_ONESHOT_EN
  typedef enum logic [1:0] {
    S_IDLE, S_HIGH, S_LOW, S_DONE
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_HIGH, S_LOW
  } state_e;
`endif

  state_e        state_q, state_d;
  logic [CB-1:0] cnt_q, cnt_d;
  logic [CB-1:0] sh_th_q, sh_th_d;
  logic [CB-1:0] sh_tl_q, sh_tl_d;
  logic [CB-1:0] act_th_q, act_th_d;
  logic [CB-1:0] act_tl_q, act_tl_d;
  logic          pend_q, pend_d;
  logic          freq_q, freq_d;
  logic          done_q, done_d;

  logic          wr_commit;
  logic          do_commit;
  state_e        start_st;
  logic [CB-1:0] start_cnt;

  always_comb begin
    sh_th_d   = sh_th_q;
    sh_tl_d   = sh_tl_q;
    wr_commit = 1'b0;
    if (bus.WR_EN) begin
      case (bus.WR_SEL)
        3'd0: wr_commit = 1'b1;
        3'd2: sh_tl_d[DW-1:0]  = bus.WR_DATA;
        3'd3: sh_tl_d[CB-1:DW] = bus.WR_DATA;
        3'd4: sh_th_d[DW-1:0]  = bus.WR_DATA;
        3'd5: sh_th_d[CB-1:DW] = bus.WR_DATA;
        default: ;
      endcase
    end
  end

  // done_q marks the final cycle, so its edge is the period boundary
  assign do_commit = pend_q & ((state_q == S_IDLE) | done_q);
  assign act_th_d  = do_commit ? sh_th_q : act_th_q;
  assign act_tl_d  = do_commit ? sh_tl_q : act_tl_q;
  assign pend_d    = wr_commit | (pend_q & ~do_commit);

  always_comb begin
    start_st  = S_IDLE;
    start_cnt = '0;
    if (act_th_d != '0) begin
      start_st  = S_HIGH;
      start_cnt = act_th_d - ONE;
    end else if (act_tl_d != '0) begin
      start_st  = S_LOW;
      start_cnt = act_tl_d - ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ENABLE) begin
          state_d = start_st;
          cnt_d   = start_cnt;
        end
      end
      S_HIGH, S_LOW: begin
        if (!bus.ENABLE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (state_q == S_HIGH &&
                     act_tl_q != '0) begin
          state_d = S_LOW;
          cnt_d   = act_tl_q - ONE;
`ifdef PULSE_WIDTH_GENERATOR_ONESHOT_EN
        end else if (bus.ONESHOT) begin
          state_d = S_DONE;
          cnt_d   = '0;
`endif
        end else begin
          state_d = start_st;
          cnt_d   = start_cnt;
        end
      end
`ifdef PULSE_WIDTH_GENERATOR_ONESHOT_EN
      S_DONE: begin
        if (!bus.ENABLE) state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign freq_d = (state_d == S_HIGH);
  assign done_d = (cnt_d == '0) &
                  ((state_d == S_LOW) |
                   ((state_d == S_HIGH) &
                    (act_tl_d == '0)));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sh_th_q  <= '0;
      sh_tl_q  <= '0;
      act_th_q <= '0;
      act_tl_q <= '0;
      pend_q   <= 1'b0;
      freq_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_th_q  <= sh_th_d;
      sh_tl_q  <= sh_tl_d;
      act_th_q <= act_th_d;
      act_tl_q <= act_tl_d;
      pend_q   <= pend_d;
      freq_q   <= freq_d;
      done_q   <= done_d;
    end
  end

  assign bus.FREQ_OUT       = freq_q;
  assign bus.PERIOD_DONE    = done_q;
  assign bus.COMMIT_PENDING = pend_q;

endmodule

// File: tb/tb_pulse_width_generator.sv
// Directed vector bench for pulse_width_generator.
// Outputs packed as {FREQ_OUT, PERIOD_DONE, COMMIT_PENDING}.
module tb_pulse_width_generator;
  logic CLK = 1'b0;
  logic RST_N;

  pulse_width_generator_if #(.DATA_WIDTH(8)) bus ();

  pulse_width_generator #(
    .COUNTER_BITS(16),
    .DATA_WIDTH(8)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       we;
    logic [2:0] sel;
    logic [7:0] dat;
    logic       en;
    logic [2:0] exp;
  } vec_t;

  vec_t vt[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t V(input logic we,
                             input logic [2:0] sel,
                             input logic [7:0] dat,
                             input logic en,
                             input logic [2:0] exp);
    vec_t v;
    v.we = we; v.sel = sel; v.dat = dat;
    v.en = en; v.exp = exp;
    return v;
  endfunction

  function automatic logic [2:0] obs();
    return {bus.FREQ_OUT, bus.PERIOD_DONE,
            bus.COMMIT_PENDING};
  endfunction

  task automatic step(input logic we,
                      input logic [2:0] sel,
                      input logic [7:0] dat,
                      input logic en);
    bus.WR_EN   = we;
    bus.WR_SEL  = sel;
    bus.WR_DATA = dat;
    bus.ENABLE  = en;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk3(input string nm, input int idx,
                      input logic [2:0] exp);
    logic [2:0] got;
    got = obs();
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got fdp=%b want %b",
               nm, idx, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got,
                      input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, got, want);
    end
  endtask

  initial begin
    int bad_f, bad_d, nd, tail, first, last;
    logic [2:0] e;

    RST_N       = 1'b0;
    bus.WR_EN   = 1'b0;
    bus.WR_SEL  = 3'd0;
    bus.WR_DATA = 8'h00;
    bus.ENABLE  = 1'b0;
`ifdef PULSE_WIDTH_GENERATOR_ONESHOT_EN
    bus.ONESHOT = 1'b0;
`endif

    // program 3/5, commit, run
    vt.push_back(V(1'b1, 3'd4, 8'h03, 1'b0, 3'b000));
    vt.push_back(V(1'b1, 3'd5, 8'h00, 1'b0, 3'b000));
    vt.push_back(V(1'b1, 3'd2, 8'h05, 1'b0, 3'b000));
    vt.push_back(V(1'b1, 3'd3, 8'h00, 1'b0, 3'b000));
    vt.push_back(V(1'b1, 3'd0, 8'h00, 1'b0, 3'b001));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b0, 3'b000));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b100));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b100));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b100));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b000));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b000));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b000));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b000));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b010));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b100));
    // shadow 2/2 written while 3/5 runs
    vt.push_back(V(1'b1, 3'd4, 8'h02, 1'b1, 3'b100));
    vt.push_back(V(1'b1, 3'd5, 8'h00, 1'b1, 3'b100));
    vt.push_back(V(1'b1, 3'd2, 8'h02, 1'b1, 3'b000));
    vt.push_back(V(1'b1, 3'd3, 8'h00, 1'b1, 3'b000));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b000));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b000));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b010));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b100));
    // commit mid-HIGH, 3/5 completes first
    vt.push_back(V(1'b1, 3'd0, 8'h00, 1'b1, 3'b101));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b101));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b001));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b001));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b001));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b001));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b011));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b100));
    // 2/2 running; shadow 3/1, commit on boundary edge
    vt.push_back(V(1'b1, 3'd4, 8'h03, 1'b1, 3'b100));
    vt.push_back(V(1'b1, 3'd5, 8'h00, 1'b1, 3'b000));
    vt.push_back(V(1'b1, 3'd2, 8'h01, 1'b1, 3'b010));
    vt.push_back(V(1'b1, 3'd0, 8'h00, 1'b1, 3'b101));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b101));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b001));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b011));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b100));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b100));
    // disable on HIGH cycle 2 of 3, then re-enable
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b0, 3'b000));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b0, 3'b000));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b100));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b100));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b100));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b010));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b1, 3'b100));
    vt.push_back(V(1'b0, 3'd0, 8'h00, 1'b0, 3'b000));

    repeat (2) @(posedge CLK);
    #1;
    chk3("reset_state", 0, 3'b000);
    #3 RST_N = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].we, vt[i].sel, vt[i].dat, vt[i].en);
      chk3("vec", i, vt[i].exp);
    end

    // TH=0x0100, TL=0
    step(1'b1, 3'd4, 8'h00, 1'b0);
    step(1'b1, 3'd5, 8'h01, 1'b0);
    step(1'b1, 3'd2, 8'h00, 1'b0);
    step(1'b1, 3'd3, 8'h00, 1'b0);
    step(1'b1, 3'd0, 8'h00, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0);
    bad_f = 0; nd = 0; first = -1; last = -1;
    for (int i = 1; i <= 512; i++) begin
      step(1'b0, 3'd0, 8'h00, 1'b1);
      if (bus.FREQ_OUT !== 1'b1) bad_f++;
      if (bus.PERIOD_DONE === 1'b1) begin
        nd++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chki("th256_low_cycles", bad_f, 0);
    chki("th256_ndone", nd, 2);
    chki("th256_first_done", first, 256);
    chki("th256_done_gap", last - first, 256);

    // TH=0, TL=4
    step(1'b1, 3'd4, 8'h00, 1'b0);
    step(1'b1, 3'd5, 8'h00, 1'b0);
    step(1'b1, 3'd2, 8'h04, 1'b0);
    step(1'b1, 3'd0, 8'h00, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0);
    bad_f = 0; bad_d = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 3'd0, 8'h00, 1'b1);
      if (bus.FREQ_OUT !== 1'b0) bad_f++;
      if (bus.PERIOD_DONE !== ((i % 4) == 0)) bad_d++;
    end
    chki("tl4_high_cycles", bad_f, 0);
    chki("tl4_done_pattern", bad_d, 0);

    // TH=TL=0 committed while running -> IDLE
    step(1'b1, 3'd2, 8'h00, 1'b1);
    step(1'b1, 3'd0, 8'h00, 1'b1);
    chk3("zero_pending", 0, 3'b001);
    nd = 0; tail = 0; bad_f = 0;
    for (int i = 15; i <= 22; i++) begin
      step(1'b0, 3'd0, 8'h00, 1'b1);
      if (bus.FREQ_OUT !== 1'b0) bad_f++;
      if (bus.PERIOD_DONE === 1'b1) begin
        nd++;
        if (i >= 19) tail++;
      end
    end
    chki("zero_high_cycles", bad_f, 0);
    chki("zero_ndone", nd, 1);
    chki("zero_idle_done", tail, 0);
    chk3("zero_idle", 0, 3'b000);

    // async reset mid-HIGH with a commit pending
    step(1'b1, 3'd4, 8'h05, 1'b0);
    step(1'b1, 3'd2, 8'h05, 1'b0);
    step(1'b1, 3'd0, 8'h00, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    step(1'b1, 3'd0, 8'h00, 1'b1);
    chk3("pre_reset", 0, 3'b101);
    #2 RST_N = 1'b0;
    #1;
    chk3("async_reset", 0, 3'b000);
    @(posedge CLK);
    #1;
    chk3("reset_hold", 0, 3'b000);
    #3 RST_N = 1'b1;
    step(1'b0, 3'd0, 8'h00, 1'b1);
    chk3("post_reset_idle", 0, 3'b000);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    chk3("post_reset_idle", 1, 3'b000);

`ifdef PULSE_WIDTH_GENERATOR_ONESHOT_EN
    step(1'b1, 3'd4, 8'h02, 1'b0);
    step(1'b1, 3'd2, 8'h03, 1'b0);
    step(1'b1, 3'd0, 8'h00, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0);
    bus.ONESHOT = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 3'd0, 8'h00, 1'b1);
      e = (i < 2) ? 3'b100 :
          (i == 4) ? 3'b010 : 3'b000;
      chk3("oneshot", i, e);
    end
    step(1'b0, 3'd0, 8'h00, 1'b0);
    chk3("oneshot_disarm", 0, 3'b000);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    chk3("oneshot_rearm", 0, 3'b100);
    bus.ONESHOT = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
